// File: rtl/cfg_bank_pkg.sv
// Shared types and constants for the configuration bank programmer.
package cfg_bank_pkg;

    localparam int unsigned DefaultAddrW = 6;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBit,
        StSetup,
        StStrobe,
        StHold,
        StFin
    } state_e;

    // Clock cycles spent per configuration bit, counting the accept cycle.
    function automatic int unsigned bit_cycles(input int unsigned setup_cyc,
                                               input int unsigned strobe_cyc,
                                               input int unsigned hold_cyc);
        return 1 + setup_cyc + strobe_cyc + hold_cyc;
    endfunction

endpackage

// File: rtl/cfg_bank_phase_timer.sv
// Loadable down-counter shared by the setup, strobe and hold phases.
// tc is high whenever the count has reached zero.
module cfg_bank_phase_timer #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             tc
);

    logic [Width-1:0] count_q;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/cfg_bank_programmer.sv
// Writer for a decoder-addressed routing-block configuration bank. Takes a start command with a
// base address and bit count, then turns each streamed bit into one timed enable strobe.
module cfg_bank_programmer
    import cfg_bank_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefaultAddrW,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_bits,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic              bit_ready,
    output logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic              data_in,
    output logic              busy,
    output logic              done,
    output logic              err_overflow
);

    localparam int unsigned MaxSh  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MaxCyc = (STROBE_CYC > MaxSh) ? STROBE_CYC : MaxSh;
    // The timer only ever holds phase length minus one.
    localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [TimerW-1:0] SetupLd  = TimerW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [TimerW-1:0] StrobeLd = TimerW'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [TimerW-1:0] HoldLd   = TimerW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    // 2^ADDR_W in the widened arithmetic used by the range check.
    localparam logic [ADDR_W+1:0] AddrSpace = {2'b01, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W+1:0] range_end;
    logic              accept;
    logic              bit_end;
    logic              timer_load;
    logic [TimerW-1:0] timer_val;
    logic              timer_tc;

    assign range_end = {2'b00, base_addr} + {1'b0, num_bits};
    assign accept    = (state_q == StWaitBit) && bit_valid && bit_ready;
    // Last cycle of a bit: end of hold, or end of strobe when there is no hold phase.
    assign bit_end   = ((state_q == StStrobe) && timer_tc && (HOLD_CYC == 0)) ||
                       ((state_q == StHold) && timer_tc);

    // Arm the phase timer on every transition into a timed phase.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if (accept) begin
            timer_load = 1'b1;
            timer_val  = (SETUP_CYC > 0) ? SetupLd : StrobeLd;
        end else if ((state_q == StSetup) && timer_tc) begin
            timer_load = 1'b1;
            timer_val  = StrobeLd;
        end else if ((state_q == StStrobe) && timer_tc) begin
            timer_load = 1'b1;
            timer_val  = HoldLd;
        end
    end

    cfg_bank_phase_timer #(
        .Width (TimerW)
    ) u_phase_timer (
        .clk      (prog_clk),
        .rst_n    (prog_reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    // Command FSM; every bank-facing output is a register.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            bit_ready    <= 1'b0;
            enable       <= 1'b0;
            address      <= '0;
            data_in      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        err_overflow <= 1'b0;
                        busy         <= 1'b1;
                        if (range_end > AddrSpace) begin
                            err_overflow <= 1'b1;
                            done         <= 1'b1;
                            state_q      <= StFin;
                        end else if (num_bits == '0) begin
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            address     <= base_addr;
                            remaining_q <= num_bits;
                            bit_ready   <= 1'b1;
                            state_q     <= StWaitBit;
                        end
                    end
                end
                StWaitBit: begin
                    if (accept) begin
                        data_in   <= bit_data;
                        bit_ready <= 1'b0;
                        if (SETUP_CYC > 0) begin
                            state_q <= StSetup;
                        end else begin
                            enable  <= 1'b1;
                            state_q <= StStrobe;
                        end
                    end
                end
                StSetup: begin
                    if (timer_tc) begin
                        enable  <= 1'b1;
                        state_q <= StStrobe;
                    end
                end
                StStrobe: begin
                    if (timer_tc) begin
                        enable <= 1'b0;
                        if (HOLD_CYC > 0) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Leaving hold is handled by the next-bit logic below.
                end
                StFin: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (bit_end) begin
                if (remaining_q == (ADDR_W+1)'(1)) begin
                    remaining_q <= '0;
                    done        <= 1'b1;
                    state_q     <= StFin;
                end else begin
                    remaining_q <= remaining_q - (ADDR_W+1)'(1);
                    address     <= address + ADDR_W'(1);
                    bit_ready   <= 1'b1;
                    state_q     <= StWaitBit;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_bank_programmer.sv
// Bench for cfg_bank_programmer: command vectors on a default-timed instance with a write
// scoreboard, plus hand sequences for reset mid-strobe and a stretched-timing instance.
module tb_cfg_bank_programmer;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;

    // Default-timing instance
    logic       start, bit_valid, bit_data;
    logic [5:0] base_addr;
    logic [6:0] num_bits;
    logic       bit_ready, enable, data_in, busy, done, err_overflow;
    logic [5:0] address;

    // Stretched-timing instance
    logic       start_b, bit_valid_b, bit_data_b;
    logic [5:0] base_addr_b;
    logic [6:0] num_bits_b;
    logic       bit_ready_b, enable_b, data_in_b, busy_b, done_b, err_overflow_b;
    logic [5:0] address_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_accept = 0;

    typedef struct {
        logic [5:0] addr;
        logic       data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [5:0] base;
        logic [6:0] num;
        logic [7:0] bits;
        int         pre;
        logic       ovf;
    } vec_t;
    vec_t vecs[8];

    cfg_bank_programmer #(
        .ADDR_W     (6),
        .SETUP_CYC  (1),
        .STROBE_CYC (1),
        .HOLD_CYC   (1)
    ) dut_a (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_bits     (num_bits),
        .bit_valid    (bit_valid),
        .bit_data     (bit_data),
        .bit_ready    (bit_ready),
        .enable       (enable),
        .address      (address),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow)
    );

    cfg_bank_programmer #(
        .ADDR_W     (6),
        .SETUP_CYC  (0),
        .STROBE_CYC (3),
        .HOLD_CYC   (2)
    ) dut_b (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start_b),
        .base_addr    (base_addr_b),
        .num_bits     (num_bits_b),
        .bit_valid    (bit_valid_b),
        .bit_data     (bit_data_b),
        .bit_ready    (bit_ready_b),
        .enable       (enable_b),
        .address      (address_b),
        .data_in      (data_in_b),
        .busy         (busy_b),
        .done         (done_b),
        .err_overflow (err_overflow_b)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor for the default instance: every rising enable consumes one scoreboard entry.
    logic       a_in = 1'b0;
    int         a_w = 0;
    logic [5:0] a_addr;
    logic       a_dat;
    always @(negedge prog_clk) begin
        wr_t e;
        if (!prog_reset_n) begin
            a_in = 1'b0;
        end else if (enable) begin
            if (!a_in) begin
                a_in   = 1'b1;
                a_w    = 1;
                a_addr = address;
                a_dat  = data_in;
                if (exp_q.size() == 0) begin
                    check("unexpected_enable", 32'(address), 32'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_addr", 32'(address), 32'(e.addr));
                    check("strobe_data", 32'(data_in), 32'(e.data));
                    check("accept_to_enable", 32'(cyc - last_accept), 32'd2);
                end
            end else begin
                a_w++;
                check("addr_stable", 32'(address), 32'(a_addr));
                check("data_stable", 32'(data_in), 32'(a_dat));
            end
            check("ready_during_enable", 32'(bit_ready), 32'd0);
        end else if (a_in) begin
            a_in = 1'b0;
            check("strobe_width", 32'(a_w), 32'd1);
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting posedge.
    task automatic send_bit(input logic d, input int pre, input logic [5:0] a);
        wr_t w;
        logic ok;
        bit_valid = 1'b0;
        repeat (pre) @(negedge prog_clk);
        bit_valid = 1'b1;
        bit_data  = d;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bit_ready) begin
                last_accept = cyc;
                w.addr = a;
                w.data = d;
                exp_q.push_back(w);
                ok = 1'b1;
            end
            @(negedge prog_clk);
            if (ok) break;
        end
        bit_valid = 1'b0;
        if (!ok) check("bit_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_cmd(input vec_t v);
        logic seen;
        start     = 1'b1;
        base_addr = v.base;
        num_bits  = v.num;
        @(negedge prog_clk);
        start = 1'b0;
        if (v.ovf || v.num == 7'd0) begin
            check("quick_done", 32'(done), 32'd1);
            check("quick_busy", 32'(busy), 32'd1);
            check("quick_ready", 32'(bit_ready), 32'd0);
            check("quick_err", 32'(err_overflow), 32'(v.ovf));
        end else begin
            for (int i = 0; i < int'(v.num); i++) begin
                send_bit(v.bits[i], v.pre, v.base + 6'(i));
            end
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge prog_clk);
            end
            check("done_seen", 32'(seen), 32'd1);
            check("done_latency", 32'(cyc - last_accept), 32'd4);
            check("fin_addr", 32'(address), 32'(v.base + 6'(v.num - 7'd1)));
            check("fin_err", 32'(err_overflow), 32'd0);
            check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        end
        @(negedge prog_clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("sticky_err", 32'(err_overflow), 32'(v.ovf));
    endtask

    // Stretched instance, one bit: called at the negedge where bit_ready_b should be high.
    task automatic b_bit(input logic d, input logic [5:0] a);
        check("b_ready", 32'(bit_ready_b), 32'd1);
        bit_valid_b = 1'b1;
        bit_data_b  = d;
        @(negedge prog_clk);
        bit_valid_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("b_enable", 32'(enable_b), (k <= 3) ? 32'd1 : 32'd0);
            check("b_addr", 32'(address_b), 32'(a));
            check("b_data", 32'(data_in_b), 32'(d));
            check("b_ready_low", 32'(bit_ready_b), 32'd0);
            @(negedge prog_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{base: 6'd0,  num: 7'd6, bits: 8'h2D, pre: 0, ovf: 1'b0};
        vecs[1] = '{base: 6'd8,  num: 7'd2, bits: 8'h01, pre: 5, ovf: 1'b0};
        vecs[2] = '{base: 6'd62, num: 7'd3, bits: 8'h00, pre: 0, ovf: 1'b1};
        vecs[3] = '{base: 6'd0,  num: 7'd1, bits: 8'h01, pre: 0, ovf: 1'b0};
        vecs[4] = '{base: 6'd5,  num: 7'd0, bits: 8'h00, pre: 0, ovf: 1'b0};
        vecs[5] = '{base: 6'd63, num: 7'd1, bits: 8'h01, pre: 0, ovf: 1'b0};
        vecs[6] = '{base: 6'd60, num: 7'd4, bits: 8'h06, pre: 0, ovf: 1'b0};
        vecs[7] = '{base: 6'd61, num: 7'd4, bits: 8'h00, pre: 0, ovf: 1'b1};

        prog_reset_n = 1'b0;
        start = 1'b0; base_addr = '0; num_bits = '0; bit_valid = 1'b0; bit_data = 1'b0;
        start_b = 1'b0; base_addr_b = '0; num_bits_b = '0; bit_valid_b = 1'b0; bit_data_b = 1'b0;
        #3;
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_ready", 32'(bit_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        repeat (2) @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i]);
        end

        // Reset while enable is high.
        start = 1'b1; base_addr = 6'd20; num_bits = 7'd2;
        @(negedge prog_clk);
        start = 1'b0;
        send_bit(1'b1, 0, 6'd20);
        for (int k = 0; k < 10; k++) begin
            if (enable) break;
            @(negedge prog_clk);
        end
        check("pre_reset_enable", 32'(enable), 32'd1);
        #1 prog_reset_n = 1'b0;
        #1;
        check("async_enable", 32'(enable), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(bit_ready), 32'd0);
        check("async_address", 32'(address), 32'd0);
        @(negedge prog_clk);
        #2 prog_reset_n = 1'b1;
        @(negedge prog_clk);
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_ready", 32'(bit_ready), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
            @(negedge prog_clk);
        end
        bit_valid = 1'b0;
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        // Stretched timing: no setup, 3-cycle strobe, 2-cycle hold.
        start_b = 1'b1; base_addr_b = 6'd10; num_bits_b = 7'd2;
        @(negedge prog_clk);
        start_b = 1'b0;
        b_bit(1'b1, 6'd10);
        b_bit(1'b0, 6'd11);
        check("b_done", 32'(done_b), 32'd1);
        check("b_fin_addr", 32'(address_b), 32'd11);
        check("b_err", 32'(err_overflow_b), 32'd0);
        @(negedge prog_clk);
        check("b_idle_busy", 32'(busy_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
